// File: rtl/axi_light_reg_slice_pkg.sv
// Shared types and widths for the AXI-lite register slice.
// Bus widths default to a 32-bit address/data bus unless the build supplies them.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_WSTRB_WIDTH
`define AXI_WSTRB_WIDTH 4
`endif

package axi_light_reg_slice_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int CH_AW = 0;
    localparam int CH_W  = 1;
    localparam int CH_B  = 2;
    localparam int CH_AR = 3;
    localparam int CH_R  = 4;

    localparam int AW_W = `AXI_ADDR_WIDTH + 3;
    localparam int W_W  = `AXI_DATA_WIDTH + `AXI_WSTRB_WIDTH;
    localparam int B_W  = 2;
    localparam int AR_W = `AXI_ADDR_WIDTH + 3;
    localparam int R_W  = `AXI_DATA_WIDTH + 2;

    // 4-bit up/down step that sticks at 15 and at 0; inc with dec is a no-op.
    function automatic logic [3:0] sat_step(input logic [3:0] v, input logic inc, input logic dec);
        logic [3:0] r;
        r = v;
        if (inc && !dec && (v != 4'd15)) begin
            r = v + 4'd1;
        end else if (dec && !inc && (v != 4'd0)) begin
            r = v - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_light_reg_slice_if.sv
// AXI-lite bus bundle; master drives requests, slave drives responses.
interface if_axi_light;
    logic [`AXI_ADDR_WIDTH-1:0]  awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [`AXI_DATA_WIDTH-1:0]  wdata;
    logic [`AXI_WSTRB_WIDTH-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [`AXI_ADDR_WIDTH-1:0]  araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [`AXI_DATA_WIDTH-1:0]  rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface

// File: rtl/axi_light_skid_buf.sv
// Two-entry skid buffer: registers valid, ready and data in both directions.
// EN=0 collapses it into a plain wire-through with no state.
module axi_light_skid_buf
    import axi_light_reg_slice_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit EN    = 1'b1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data
);

    generate
        if (EN) begin : g_slice
            skid_state_t      r_state;
            skid_state_t      w_state_nxt;
            logic [WIDTH-1:0] r_main_data;
            logic [WIDTH-1:0] r_skid_data;
            logic             w_in_hs;
            logic             w_out_hs;
            logic             w_load_main;
            logic             w_load_skid;
            logic             w_main_from_skid;

            // Ready and valid decode straight from the state register.
            assign o_in_ready  = (r_state != FULL);
            assign o_out_valid = (r_state != EMPTY);
            assign o_out_data  = r_main_data;
            assign w_in_hs     = i_in_valid & o_in_ready;
            assign w_out_hs    = o_out_valid & i_out_ready;

            // State and payload registers; payload only moves on a load strobe.
            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    r_state     <= EMPTY;
                    r_main_data <= '0;
                    r_skid_data <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    if (w_load_main) begin
                        r_main_data <= i_in_data;
                    end else if (w_main_from_skid) begin
                        r_main_data <= r_skid_data;
                    end
                    if (w_load_skid) begin
                        r_skid_data <= i_in_data;
                    end
                end
            end

            // Next state and load strobes from the two handshakes.
            always_comb begin
                w_state_nxt      = r_state;
                w_load_main      = 1'b0;
                w_load_skid      = 1'b0;
                w_main_from_skid = 1'b0;
                case (r_state)
                    EMPTY: begin
                        if (w_in_hs) begin
                            w_state_nxt = ONE;
                            w_load_main = 1'b1;
                        end
                    end
                    ONE: begin
                        if (w_in_hs && !w_out_hs) begin
                            w_state_nxt = FULL;
                            w_load_skid = 1'b1;
                        end else if (w_in_hs && w_out_hs) begin
                            w_load_main = 1'b1;
                        end else if (w_out_hs) begin
                            w_state_nxt = EMPTY;
                        end
                    end
                    FULL: begin
                        if (w_out_hs) begin
                            w_state_nxt      = ONE;
                            w_main_from_skid = 1'b1;
                        end
                    end
                    default: w_state_nxt = EMPTY;
                endcase
            end
        end else begin : g_wire
            assign o_out_valid = i_in_valid;
            assign o_in_ready  = i_out_ready;
            assign o_out_data  = i_in_data;
        end
    endgenerate

endmodule

// File: rtl/axi_light_reg_slice.sv
// AXI-lite register slice: one skid buffer per channel, payloads untouched.
// Optional statistics outputs (and CNT_WIDTH) exist only when
// AXI_LIGHT_REG_SLICE_STATS_EN is defined.
module axi_light_reg_slice
    import axi_light_reg_slice_pkg::*;
#(
    parameter logic [4:0] CH_EN = 5'b11111
`ifdef AXI_LIGHT_REG_SLICE_STATS_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic               clk,
    input  logic               res_n,
    if_axi_light.slave         s_axi,
    if_axi_light.master        m_axi
`ifdef AXI_LIGHT_REG_SLICE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] wr_cnt,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    output logic [3:0]           wr_outstanding,
    output logic [3:0]           rd_outstanding
`endif
);

    logic [AW_W-1:0] w_aw_out;
    logic [W_W-1:0]  w_w_out;
    logic [B_W-1:0]  w_b_out;
    logic [AR_W-1:0] w_ar_out;
    logic [R_W-1:0]  w_r_out;

    axi_light_skid_buf #(.WIDTH(AW_W), .EN(CH_EN[CH_AW])) u_aw (
        .clk(clk), .res_n(res_n),
        .i_in_valid(s_axi.awvalid), .o_in_ready(s_axi.awready),
        .i_in_data({s_axi.awaddr, s_axi.awprot}),
        .o_out_valid(m_axi.awvalid), .i_out_ready(m_axi.awready),
        .o_out_data(w_aw_out)
    );
    assign {m_axi.awaddr, m_axi.awprot} = w_aw_out;

    axi_light_skid_buf #(.WIDTH(W_W), .EN(CH_EN[CH_W])) u_w (
        .clk(clk), .res_n(res_n),
        .i_in_valid(s_axi.wvalid), .o_in_ready(s_axi.wready),
        .i_in_data({s_axi.wdata, s_axi.wstrb}),
        .o_out_valid(m_axi.wvalid), .i_out_ready(m_axi.wready),
        .o_out_data(w_w_out)
    );
    assign {m_axi.wdata, m_axi.wstrb} = w_w_out;

    axi_light_skid_buf #(.WIDTH(B_W), .EN(CH_EN[CH_B])) u_b (
        .clk(clk), .res_n(res_n),
        .i_in_valid(m_axi.bvalid), .o_in_ready(m_axi.bready),
        .i_in_data(m_axi.bresp),
        .o_out_valid(s_axi.bvalid), .i_out_ready(s_axi.bready),
        .o_out_data(w_b_out)
    );
    assign s_axi.bresp = w_b_out;

    axi_light_skid_buf #(.WIDTH(AR_W), .EN(CH_EN[CH_AR])) u_ar (
        .clk(clk), .res_n(res_n),
        .i_in_valid(s_axi.arvalid), .o_in_ready(s_axi.arready),
        .i_in_data({s_axi.araddr, s_axi.arprot}),
        .o_out_valid(m_axi.arvalid), .i_out_ready(m_axi.arready),
        .o_out_data(w_ar_out)
    );
    assign {m_axi.araddr, m_axi.arprot} = w_ar_out;

    axi_light_skid_buf #(.WIDTH(R_W), .EN(CH_EN[CH_R])) u_r (
        .clk(clk), .res_n(res_n),
        .i_in_valid(m_axi.rvalid), .o_in_ready(m_axi.rready),
        .i_in_data({m_axi.rdata, m_axi.rresp}),
        .o_out_valid(s_axi.rvalid), .i_out_ready(s_axi.rready),
        .o_out_data(w_r_out)
    );
    assign {s_axi.rdata, s_axi.rresp} = w_r_out;

`ifdef AXI_LIGHT_REG_SLICE_STATS_EN
    logic [CNT_WIDTH-1:0] r_wr_cnt;
    logic [CNT_WIDTH-1:0] r_rd_cnt;
    logic [3:0]           r_wr_out;
    logic [3:0]           r_rd_out;
    logic                 w_aw_acc;
    logic                 w_ar_acc;
    logic                 w_b_done;
    logic                 w_r_done;

    // All events are observed on the master-facing side.
    assign w_aw_acc = s_axi.awvalid & s_axi.awready;
    assign w_ar_acc = s_axi.arvalid & s_axi.arready;
    assign w_b_done = s_axi.bvalid & s_axi.bready;
    assign w_r_done = s_axi.rvalid & s_axi.rready;

    // Completion counters wrap; outstanding counters saturate.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_wr_out <= 4'd0;
            r_rd_out <= 4'd0;
        end else begin
            if (w_b_done) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_r_done) r_rd_cnt <= r_rd_cnt + 1'b1;
            r_wr_out <= sat_step(r_wr_out, w_aw_acc, w_b_done);
            r_rd_out <= sat_step(r_rd_out, w_ar_acc, w_r_done);
        end
    end

    assign wr_cnt         = r_wr_cnt;
    assign rd_cnt         = r_rd_cnt;
    assign wr_outstanding = r_wr_out;
    assign rd_outstanding = r_rd_out;
`endif

endmodule
